// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source codes and
// the sequential increment.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_JAL  = 3'd1,
        SEL_JALR = 3'd2,
        SEL_BR   = 3'd3,
        SEL_TRAP = 3'd4,
        SEL_MRET = 3'd5,
        SEL_RET  = 3'd6,
        SEL_RSVD = 3'd7
    } pc_sel_t;

    localparam int unsigned INC = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack as a circular buffer: a full push overwrites the oldest
// entry, and push+pop together rewrite the top in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [XLEN-1:0]              wdata,
    output logic [XLEN-1:0]              top,
    output logic                         empty,
    output logic [$clog2(RAS_DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] cnt;
    logic             pop_ok;

    // ptr addresses the next free slot; the top lives one below it
    assign top_idx = ptr - PTR_W'(1);
    assign top     = mem[top_idx];
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push && pop_ok) begin
            ptr <= ptr;
            cnt <= cnt;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (cnt != CNT_W'(RAS_DEPTH))
                cnt <= cnt + CNT_W'(1);
        end else if (pop_ok) begin
            ptr <= ptr - PTR_W'(1);
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            if (pop_ok)
                mem[top_idx] <= wdata;
            else
                mem[ptr] <= wdata;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC source selection, alignment guard, fetch-valid
// flag and an attached return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     RAS_DEPTH = 4
)(
    input  logic            clk,
    input  logic            PC_RST_N,
    input  logic            PC_WRITE,
    input  logic [2:0]      PC_SEL,
    input  logic            PC_READY,
    input  logic [XLEN-1:0] JAL_TGT,
    input  logic [XLEN-1:0] JALR_TGT,
    input  logic [XLEN-1:0] BR_TGT,
    input  logic [XLEN-1:0] MTVEC,
    input  logic [XLEN-1:0] MEPC,
    input  logic            RAS_PUSH,
    output logic [XLEN-1:0] PC_COUNT,
    output logic [XLEN-1:0] PC_NEXT4,
    output logic            PC_VALID,
    output logic            PC_MISALIGN,
    output logic            RAS_EMPTY
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    pc_sel_t          sel;
    logic [XLEN-1:0]  pc_p0;
    logic             vld_p0;
    logic [XLEN-1:0]  tgt;
    logic [XLEN-1:0]  ras_top;
    logic [CNT_W-1:0] ras_cnt;
    logic             ras_empty;
    logic             redirect;
    logic             accept;

    assign sel      = pc_sel_t'(PC_SEL);
    assign PC_NEXT4 = pc_p0 + XLEN'(INC);

    always_comb begin
        tgt = PC_NEXT4;
        case (sel)
            SEL_JAL:  tgt = JAL_TGT;
            SEL_JALR: tgt = JALR_TGT;
            SEL_BR:   tgt = BR_TGT;
            SEL_TRAP: tgt = MTVEC;
            SEL_MRET: tgt = MEPC;
            SEL_RET:  tgt = (ras_cnt != '0) ? ras_top : JALR_TGT;
            default:  tgt = PC_NEXT4;
        endcase
    end

    // A misaligned target blocks the whole update; the trap path is external
    assign PC_MISALIGN = |tgt[1:0];
    assign redirect    = (sel != SEL_SEQ);
    assign accept      = PC_WRITE && !PC_MISALIGN && (redirect || (vld_p0 && PC_READY));

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (PC_RST_N),
        .push  (accept && RAS_PUSH),
        .pop   (accept && (sel == SEL_RET)),
        .wdata (PC_NEXT4),
        .top   (ras_top),
        .empty (ras_empty),
        .count (ras_cnt)
    );

    // Stage p0: architectural PC and fetch-valid flag
    always_ff @(posedge clk) begin
        if (!PC_RST_N) begin
            pc_p0  <= RESET_VEC;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= 1'b1;
            if (accept)
                pc_p0 <= tgt;
        end
    end

    assign PC_COUNT  = pc_p0;
    assign PC_VALID  = vld_p0;
    assign RAS_EMPTY = ras_empty;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by random traffic, all checked
// against a queue-based behavioural model of the PC and return stack.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n, wr, ready, push;
    logic [2:0]  sel_in;
    logic [31:0] jal_t, jalr_t, br_t, mtvec, mepc;
    logic [31:0] pc_count, pc_next4;
    logic        pc_valid, pc_mis, ras_empty;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc;
    bit          m_vld;
    bit          m_known = 0;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_unit #(.XLEN(32), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .PC_RST_N    (rst_n),
        .PC_WRITE    (wr),
        .PC_SEL      (sel_in),
        .PC_READY    (ready),
        .JAL_TGT     (jal_t),
        .JALR_TGT    (jalr_t),
        .BR_TGT      (br_t),
        .MTVEC       (mtvec),
        .MEPC        (mepc),
        .RAS_PUSH    (push),
        .PC_COUNT    (pc_count),
        .PC_NEXT4    (pc_next4),
        .PC_VALID    (pc_valid),
        .PC_MISALIGN (pc_mis),
        .RAS_EMPTY   (ras_empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_target();
        case (sel_in)
            3'd1:    return jal_t;
            3'd2:    return jalr_t;
            3'd3:    return br_t;
            3'd4:    return mtvec;
            3'd5:    return mepc;
            3'd6:    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : jalr_t;
            default: return m_pc + 32'd4;
        endcase
    endfunction

    // One clock: check combinational outputs, advance model and DUT, check state
    task automatic cycle(input string tag);
        logic [31:0] t, link;
        bit          acc;
        #1;
        if (m_known) begin
            t = m_target();
            check({tag, "/next4"}, pc_next4, m_pc + 32'd4);
            check({tag, "/misalign"}, {31'b0, pc_mis}, {31'b0, (t[1:0] != 2'b00)});
        end
        @(posedge clk);
        if (!rst_n) begin
            m_pc    = RV;
            m_vld   = 0;
            m_known = 1;
            m_ras.delete();
        end else if (m_known) begin
            t    = m_target();
            link = m_pc + 32'd4;
            acc  = wr && (t[1:0] == 2'b00) && ((sel_in != 3'd0) || (m_vld && ready));
            if (acc) begin
                m_pc = t;
                if (push) begin
                    if (sel_in == 3'd6 && m_ras.size() > 0) begin
                        m_ras[m_ras.size()-1] = link;
                    end else begin
                        m_ras.push_back(link);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
                end else if (sel_in == 3'd6 && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
            m_vld = 1;
        end
        #1;
        if (m_known) begin
            check({tag, "/pc"}, pc_count, m_pc);
            check({tag, "/valid"}, {31'b0, pc_valid}, {31'b0, m_vld});
            check({tag, "/empty"}, {31'b0, ras_empty}, {31'b0, (m_ras.size() == 0)});
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] s,
                         input logic rd, input logic p);
        rst_n  = r;
        wr     = w;
        sel_in = s;
        ready  = rd;
        push   = p;
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 7) != 0) v[1:0] = 2'b00;
        return v;
    endfunction

    logic [31:0] lifo_exp [5];

    initial begin
        jal_t = 0; jalr_t = 0; br_t = 0; mtvec = 0; mepc = 0;
        drive(0, 1, 3'd3, 1, 1);
        br_t = 32'h40;
        cycle("rst0");
        cycle("rst1");
        check("reset/pc", pc_count, RV);
        check("reset/valid", {31'b0, pc_valid}, 32'd0);
        check("reset/next4", pc_next4, RV + 32'd4);
        check("reset/empty", {31'b0, ras_empty}, 32'd1);

        drive(1, 1, 3'd0, 1, 0);
        cycle("seq1"); check("seq1/abs", pc_count, 32'h0);
        cycle("seq2"); check("seq2/abs", pc_count, 32'h4);
        cycle("seq3"); check("seq3/abs", pc_count, 32'h8);

        drive(1, 1, 3'd3, 0, 0); br_t = 32'h100;
        cycle("br");    check("br/abs", pc_count, 32'h100);
        drive(1, 1, 3'd0, 0, 0);
        cycle("hold");  check("hold/abs", pc_count, 32'h100);

        drive(1, 1, 3'd1, 1, 0); jal_t = 32'h10;
        cycle("jal10");
        drive(1, 1, 3'd1, 1, 1); jal_t = 32'h200;
        cycle("call");
        drive(1, 1, 3'd6, 1, 0);
        cycle("ret");   check("ret/abs", pc_count, 32'h14);
        check("ret/empty_abs", {31'b0, ras_empty}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 3'd1, 1, 1); jal_t = 32'h1000 + i * 32'h100;
            cycle("calln");
        end
        lifo_exp = '{32'h1304, 32'h1204, 32'h1104, 32'h1004, 32'h2000};
        jalr_t = 32'h2000;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 3'd6, 1, 0);
            cycle("retn");
            check("retn/lifo", pc_count, lifo_exp[i]);
        end

        drive(1, 1, 3'd2, 1, 0); jalr_t = 32'h102;
        #1; check("jalr/mis_abs", {31'b0, pc_mis}, 32'd1);
        cycle("jalr_mis"); check("jalr/hold_abs", pc_count, 32'h2000);
        drive(1, 1, 3'd4, 1, 0); mtvec = 32'h300;
        cycle("trap");  check("trap/abs", pc_count, 32'h300);

        drive(1, 1, 3'd1, 1, 1); jal_t = 32'h400;
        cycle("precall");
        drive(0, 1, 3'd3, 1, 1); br_t = 32'h500;
        cycle("rst_br");
        check("rst_br/pc", pc_count, RV);
        check("rst_br/empty", {31'b0, ras_empty}, 32'd1);
        check("rst_br/valid", {31'b0, pc_valid}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
                  3'($urandom_range(0, 6)), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0));
            jal_t  = rnd_tgt();
            jalr_t = rnd_tgt();
            br_t   = rnd_tgt();
            mtvec  = rnd_tgt();
            mepc   = rnd_tgt();
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
